// File: rtl/mem_pool_write_xbar.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pool_write_xbar
//  Purpose  : Write crossbar from SRC_NUM requesters to IMG_GRP_NUM image
//             memory groups. One global round-robin pass per cycle grants
//             whole (possibly multi-group broadcast) requests atomically;
//             granted writes reach the pool through one register per group.
//  Option   : `define MPW_STALL_STAT_EN adds per-source 16-bit stall counters
//             (stat_clr_i / stall_cnt_o).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_pool_write_xbar #(
    parameter int IMG_GRP_NUM     = 3,
    parameter int SRC_NUM         = 3,
    parameter int ROW_PARA        = 4,
    parameter int CHL_PARA        = 8,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int BANK_UNIT_WIDTH = 8,
    localparam int ADDR_W = ROW_PARA * BANK_ADDR_WIDTH,
    localparam int DATA_W = ROW_PARA * CHL_PARA * BANK_UNIT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SRC_NUM*IMG_GRP_NUM-1:0]  src_group_id_i,
    input  logic [SRC_NUM*ROW_PARA-1:0]     src_bank_en_i,
    input  logic [SRC_NUM*ADDR_W-1:0]       src_addr_i,
    input  logic [SRC_NUM*DATA_W-1:0]       src_data_i,
    output logic [SRC_NUM-1:0]              src_ready_o,
    output logic [IMG_GRP_NUM*ROW_PARA-1:0] write_bank_en_o,
    output logic [IMG_GRP_NUM*ADDR_W-1:0]   write_addr_o,
    output logic [IMG_GRP_NUM*DATA_W-1:0]   write_data_o
`ifdef MPW_STALL_STAT_EN
    ,
    input  logic                            stat_clr_i,
    output logic [SRC_NUM*16-1:0]           stall_cnt_o
`endif
);

    localparam int c_PTR_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;

    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic [c_PTR_W-1:0]     w_rr_next;
    logic [SRC_NUM-1:0]     w_grant;
    logic [SRC_NUM-1:0]     w_valid;
    logic [IMG_GRP_NUM-1:0] w_claimed;
    logic [c_PTR_W-1:0]     w_owner [IMG_GRP_NUM];
    logic                   w_any;
    int                     w_first;
    int                     w_idx;
    logic [IMG_GRP_NUM-1:0] w_mask;

    // Round-robin pass: visit sources from r_rr_ptr, grant a source only if
    // none of its groups is already claimed (keeps broadcasts atomic).
    always_comb begin
        w_claimed = '0;
        w_grant   = '0;
        w_valid   = '0;
        w_any     = 1'b0;
        w_first   = 0;
        w_idx     = 0;
        w_mask    = '0;
        for (int g = 0; g < IMG_GRP_NUM; g++) begin
            w_owner[g] = '0;
        end
        for (int k = 0; k < SRC_NUM; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= SRC_NUM) begin
                w_idx = w_idx - SRC_NUM;
            end
            w_mask = src_group_id_i[w_idx*IMG_GRP_NUM +: IMG_GRP_NUM];
            w_valid[w_idx] = |w_mask;
            if ((|w_mask) && ((w_mask & w_claimed) == '0)) begin
                w_grant[w_idx] = 1'b1;
                w_claimed      = w_claimed | w_mask;
                for (int g = 0; g < IMG_GRP_NUM; g++) begin
                    if (w_mask[g]) begin
                        w_owner[g] = c_PTR_W'(w_idx);
                    end
                end
                if (!w_any) begin
                    w_any   = 1'b1;
                    w_first = w_idx;
                end
            end
        end
    end

    // Pointer advances past the first source granted in visit order.
    always_comb begin
        w_rr_next = r_rr_ptr;
        if (w_any) begin
            w_rr_next = (w_first + 1 >= SRC_NUM) ? '0 : c_PTR_W'(w_first + 1);
        end
    end

    // Reset suppresses every grant so nothing is accepted while rst_n is low.
    assign src_ready_o = w_grant & {SRC_NUM{rst_n}};

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_next;
        end
    end

    // Per-group output stage: load the owning source, otherwise drop the
    // enables while address/data keep their previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_bank_en_o <= '0;
            write_addr_o    <= '0;
            write_data_o    <= '0;
        end else begin
            for (int g = 0; g < IMG_GRP_NUM; g++) begin
                if (w_claimed[g]) begin
                    write_bank_en_o[g*ROW_PARA +: ROW_PARA] <=
                        src_bank_en_i[int'(w_owner[g])*ROW_PARA +: ROW_PARA];
                    write_addr_o[g*ADDR_W +: ADDR_W] <=
                        src_addr_i[int'(w_owner[g])*ADDR_W +: ADDR_W];
                    write_data_o[g*DATA_W +: DATA_W] <=
                        src_data_i[int'(w_owner[g])*DATA_W +: DATA_W];
                end else begin
                    write_bank_en_o[g*ROW_PARA +: ROW_PARA] <= '0;
                end
            end
        end
    end

`ifdef MPW_STALL_STAT_EN
    logic [15:0] r_stall_cnt [SRC_NUM];

    // Saturating stall counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SRC_NUM; s++) begin
                r_stall_cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SRC_NUM; s++) begin
                if (stat_clr_i) begin
                    r_stall_cnt[s] <= '0;
                end else if (w_valid[s] && !w_grant[s] && (r_stall_cnt[s] != 16'hFFFF)) begin
                    r_stall_cnt[s] <= r_stall_cnt[s] + 16'd1;
                end
            end
        end
    end

    // Flatten counters onto the packed status bus.
    always_comb begin
        stall_cnt_o = '0;
        for (int s = 0; s < SRC_NUM; s++) begin
            stall_cnt_o[s*16 +: 16] = r_stall_cnt[s];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_pool_write_xbar.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_pool_write_xbar
//  Purpose  : Directed, table-driven bench for mem_pool_write_xbar
//             (3 sources x 3 groups, 4 banks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_pool_write_xbar;

    localparam int G  = 3;
    localparam int S  = 3;
    localparam int B  = 4;
    localparam int AW = 48;
    localparam int DW = 256;

    logic              clk;
    logic              rst_n;
    logic [S*G-1:0]    src_group_id_i;
    logic [S*B-1:0]    src_bank_en_i;
    logic [S*AW-1:0]   src_addr_i;
    logic [S*DW-1:0]   src_data_i;
    logic [S-1:0]      src_ready_o;
    logic [G*B-1:0]    write_bank_en_o;
    logic [G*AW-1:0]   write_addr_o;
    logic [G*DW-1:0]   write_data_o;
`ifdef MPW_STALL_STAT_EN
    logic              stat_clr_i;
    logic [S*16-1:0]   stall_cnt_o;
`endif

    mem_pool_write_xbar dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_group_id_i  (src_group_id_i),
        .src_bank_en_i   (src_bank_en_i),
        .src_addr_i      (src_addr_i),
        .src_data_i      (src_data_i),
        .src_ready_o     (src_ready_o),
        .write_bank_en_o (write_bank_en_o),
        .write_addr_o    (write_addr_o),
        .write_data_o    (write_data_o)
`ifdef MPW_STALL_STAT_EN
        ,
        .stat_clr_i      (stat_clr_i),
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gid: 3 bits per source; ben: 4 bits per source; rdy expected ready;
    // wen expected registered enables; own: 2 bits per group, 3 = not written.
    typedef struct {
        logic [8:0]  gid;
        logic [11:0] ben;
        logic [2:0]  rdy;
        logic [11:0] wen;
        logic [5:0]  own;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic [AW-1:0] exp_addr [G];
    logic [DW-1:0] exp_data [G];

    function automatic logic [AW-1:0] addr_of(int s, int v);
        return 48'h123 + 48'(v) * 48'h1000 + 48'(s) * 48'h10;
    endfunction

    function automatic logic [DW-1:0] data_of(int s, int v);
        logic [31:0] w;
        w = 32'hA5A5_0000 ^ 32'(v * 256 + s);
        return {8{w}};
    endfunction

    task automatic add(input logic [8:0] gid, input logic [11:0] ben,
                       input logic [2:0] rdy, input logic [11:0] wen,
                       input logic [5:0] own);
        vec_t v;
        v.gid = gid; v.ben = ben; v.rdy = rdy; v.wen = wen; v.own = own;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive, check ready, clock, check registered outputs.
    task automatic apply(input int vi);
        vec_t v;
        logic [1:0] o;
        v = vecs[vi];
        src_group_id_i = v.gid;
        src_bank_en_i  = v.ben;
        for (int s = 0; s < S; s++) begin
            src_addr_i[s*AW +: AW] = addr_of(s, vi);
            src_data_i[s*DW +: DW] = data_of(s, vi);
        end
        #1;
        chk($sformatf("ready v%0d", vi), 256'(src_ready_o), 256'(v.rdy));
        for (int g = 0; g < G; g++) begin
            o = v.own[g*2 +: 2];
            if (o != 2'd3) begin
                exp_addr[g] = addr_of(int'(o), vi);
                exp_data[g] = data_of(int'(o), vi);
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("wen v%0d", vi), 256'(write_bank_en_o), 256'(v.wen));
        chk($sformatf("addr v%0d", vi), 256'({exp_addr[2], exp_addr[1], exp_addr[0]}),
            256'(write_addr_o));
        for (int g = 0; g < G; g++) begin
            chk($sformatf("data v%0d g%0d", vi, g), write_data_o[g*DW +: DW], exp_data[g]);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        src_group_id_i = '0;
        src_bank_en_i  = '0;
        src_addr_i     = '0;
        src_data_i     = '0;
`ifdef MPW_STALL_STAT_EN
        stat_clr_i     = 1'b0;
`endif
        for (int g = 0; g < G; g++) begin
            exp_addr[g] = '0;
            exp_data[g] = '0;
        end

        //    gid             ben      rdy     wen      own (g2,g1,g0)
        add(9'b000_000_000, 12'h000, 3'b000, 12'h000, {2'd3, 2'd3, 2'd3}); // idle, ptr 0
        add(9'b000_010_000, 12'h0F0, 3'b010, 12'h0F0, {2'd3, 2'd1, 2'd3}); // single, ptr->2
        add(9'b100_000_001, 12'hC03, 3'b101, 12'hC03, {2'd2, 2'd3, 2'd0}); // disjoint, ptr->0
        add(9'b001_001_001, 12'h421, 3'b001, 12'h001, {2'd3, 2'd3, 2'd0}); // contention
        add(9'b001_001_001, 12'h421, 3'b010, 12'h002, {2'd3, 2'd3, 2'd1});
        add(9'b001_001_001, 12'h421, 3'b100, 12'h004, {2'd3, 2'd3, 2'd2});
        add(9'b001_001_001, 12'h421, 3'b001, 12'h001, {2'd3, 2'd3, 2'd0});
        add(9'b001_001_001, 12'h421, 3'b010, 12'h002, {2'd3, 2'd3, 2'd1});
        add(9'b001_001_001, 12'h421, 3'b100, 12'h004, {2'd3, 2'd3, 2'd2}); // ptr->0
        add(9'b000_000_001, 12'h001, 3'b001, 12'h001, {2'd3, 2'd3, 2'd0}); // ptr->1
        add(9'b000_010_011, 12'h05F, 3'b010, 12'h050, {2'd3, 2'd1, 2'd3}); // bcast blocked
        add(9'b000_000_011, 12'h00F, 3'b001, 12'h0FF, {2'd3, 2'd0, 2'd0}); // bcast whole
        add(9'b111_000_000, 12'h000, 3'b100, 12'h000, {2'd2, 2'd2, 2'd2}); // no-op write
        add(9'b100_011_001, 12'h421, 3'b101, 12'h401, {2'd2, 2'd3, 2'd0}); // partial overlap

        // Reset state, with a request present while reset is held.
        src_group_id_i = 9'b000_010_000;
        src_bank_en_i  = 12'h0F0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", 256'(src_ready_o), 256'(0));
        chk("rst wen", 256'(write_bank_en_o), 256'(0));
        chk("rst addr", 256'(write_addr_o), 256'(0));
        chk("rst data", write_data_o[DW-1:0], 256'(0));
        src_group_id_i = '0;
        src_bank_en_i  = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i);
        end

        // Asynchronous reset in the middle of a burst.
        src_group_id_i = 9'b001_001_001;
        src_bank_en_i  = 12'h421;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("burst wen pre-reset", 256'(write_bank_en_o == 12'h000), 256'(0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst wen", 256'(write_bank_en_o), 256'(0));
        chk("async rst ready", 256'(src_ready_o), 256'(0));
        chk("async rst addr", 256'(write_addr_o), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("restart ready", 256'(src_ready_o), 256'(3'b001));
        @(posedge clk);
        #1;
        chk("restart wen", 256'(write_bank_en_o), 256'(12'h001));

`ifdef MPW_STALL_STAT_EN
        @(negedge clk);
        rst_n = 1'b0;
        src_group_id_i = 9'b100_000_100;
        src_bank_en_i  = 12'h40F;
        #1;
        chk("stat rst", 256'(stall_cnt_o), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        // Sources 0 and 2 alternate on group 2: each waits in 5 of 10 cycles.
        repeat (10) @(posedge clk);
        #1;
        chk("stall src2", 256'(stall_cnt_o[47:32]), 256'(5));
        chk("stall src0", 256'(stall_cnt_o[15:0]), 256'(5));
        chk("stall src1", 256'(stall_cnt_o[31:16]), 256'(0));
        @(negedge clk);
        src_group_id_i = 9'b100_000_100;
        stat_clr_i = 1'b1;
        @(posedge clk);
        #1;
        chk("stall clr", 256'(stall_cnt_o), 256'(0));
        @(negedge clk);
        stat_clr_i = 1'b0;
        src_group_id_i = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
